// File: rtl/dataplane_port_arbiter.sv
// Packet-atomic N-to-1 ingress arbiter (round-robin or fixed priority) with max-length truncation.
// Optional per-port packet/truncation counters are enabled by defining PORT_STATS_EN.
module dataplane_port_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_W        = 8,
    parameter int MAX_PKT_BEATS = 1518,
    parameter int ARB_MODE      = 0,
    parameter int PORT_W        = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_last,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [PORT_W-1:0]           out_port,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        trunc_pulse
`ifdef PORT_STATS_EN
    ,
    input  logic [PORT_W-1:0]           stat_sel,
    output logic [31:0]                 stat_pkts,
    output logic [31:0]                 stat_truncs
`endif
);

    localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFwd     = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [DATA_W-1:0] data_arr [NUM_PORTS];
    logic [PORT_W-1:0] winner;
    logic [PORT_W-1:0] next_rr;
    logic              g_valid, g_last, at_limit;
    logic [DATA_W-1:0] g_data;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign data_arr[p] = in_data[p*DATA_W +: DATA_W];
    end

    assign g_valid  = in_valid[grant_q];
    assign g_last   = in_last[grant_q];
    assign g_data   = data_arr[grant_q];
    assign at_limit = (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1));
    assign next_rr  = (grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
    assign busy     = (state_q != StIdle);

    // Round-robin scans upward from rr_ptr; fixed priority scans from index 0.
    always_comb begin
        int          idx;
        logic        found;
        logic [PORT_W-1:0] cand;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 1) idx = k;
            else               idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
            cand = PORT_W'(idx);
            if (!found && in_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        in_ready    = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        out_port    = '0;
        trunc_pulse = 1'b0;
        case (state_q)
            StFwd: begin
                out_valid         = g_valid;
                out_data          = g_data;
                out_port          = grant_q;
                // A beat at the length limit without a real last closes the packet early.
                out_last          = g_valid & (g_last | at_limit);
                in_ready[grant_q] = out_ready;
                trunc_pulse       = g_valid & out_ready & at_limit & ~g_last;
            end
            StDiscard: begin
                in_ready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            StIdle: begin
                if (|in_valid) begin
                    grant_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = StFwd;
                end
            end
            StFwd: begin
                if (g_valid && out_ready) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (g_last) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_rr;
                    end else if (at_limit) begin
                        state_d = StDiscard;
                    end
                end
            end
            StDiscard: begin
                if (g_valid && g_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_rr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef PORT_STATS_EN
    logic [31:0] pkts_q   [NUM_PORTS];
    logic [31:0] truncs_q [NUM_PORTS];
    logic        pkt_done;

    assign pkt_done = ((state_q == StFwd) && g_valid && out_ready && g_last) ||
                      ((state_q == StDiscard) && g_valid && g_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkts_q[p]   <= '0;
                truncs_q[p] <= '0;
            end
        end else begin
            if (pkt_done && (pkts_q[grant_q] != '1)) begin
                pkts_q[grant_q] <= pkts_q[grant_q] + 32'd1;
            end
            if (trunc_pulse && (truncs_q[grant_q] != '1)) begin
                truncs_q[grant_q] <= truncs_q[grant_q] + 32'd1;
            end
        end
    end

    assign stat_pkts   = pkts_q[stat_sel];
    assign stat_truncs = truncs_q[stat_sel];
`endif

endmodule

// File: tb/tb_dataplane_port_arbiter.sv
// Scoreboard bench for dataplane_port_arbiter: packet-level reference model, randomized rounds,
// directed latency/truncation/stall/reset cases, plus a fixed-priority instance.
module tb_dataplane_port_arbiter;

    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int PW   = 2;
    localparam int MAXB = 6;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] port;
        logic          trunc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   in_valid, in_last, in_ready;
    logic [NP*DW-1:0] in_data;
    logic            out_valid, out_last, out_ready, busy, trunc_pulse;
    logic [DW-1:0]   out_data;
    logic [PW-1:0]   out_port;

    logic [NP-1:0]   fp_in_valid, fp_in_last, fp_in_ready;
    logic [NP*DW-1:0] fp_in_data;
    logic            fp_out_valid, fp_out_last, fp_busy, fp_trunc;
    logic [DW-1:0]   fp_out_data;
    logic [PW-1:0]   fp_out_port;

`ifdef PORT_STATS_EN
    logic [PW-1:0]   stat_sel;
    logic [31:0]     stat_pkts, stat_truncs, fp_stat_pkts, fp_stat_truncs;
`endif

    always #5 clk = ~clk;

    dataplane_port_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .MAX_PKT_BEATS(MAXB), .ARB_MODE(0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_port(out_port),
        .out_ready(out_ready), .busy(busy), .trunc_pulse(trunc_pulse)
`ifdef PORT_STATS_EN
        , .stat_sel(stat_sel), .stat_pkts(stat_pkts), .stat_truncs(stat_truncs)
`endif
    );

    dataplane_port_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .MAX_PKT_BEATS(MAXB), .ARB_MODE(1)
    ) u_dut_fp (
        .clk(clk), .rst(rst),
        .in_valid(fp_in_valid), .in_data(fp_in_data), .in_last(fp_in_last),
        .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_last(fp_out_last),
        .out_port(fp_out_port), .out_ready(1'b1), .busy(fp_busy), .trunc_pulse(fp_trunc)
`ifdef PORT_STATS_EN
        , .stat_sel(2'd0), .stat_pkts(fp_stat_pkts), .stat_truncs(fp_stat_truncs)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    ready_mode = 0;
    bit    gap_en = 1'b0;
    bit    timing_en = 1'b0;
    int    fire_off[$];
    beat_t src_q [NP][$];
    exp_t  sb_q[$];
    int    model_rr = 0;
    int    model_pkts [NP];
    int    model_truncs [NP];
    int    r_len [NP];
    logic [DW-1:0] r_start [NP];
    int    fp_fires = 0;
    int    fp_cnt [NP];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sources: first beat of a packet is held valid until taken; later beats may gap.
    initial begin : driver
        logic [NP-1:0] fire_s, fp_fire_s;
        logic          hold;
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        fp_in_valid = 4'b0110; fp_in_last = '0; fp_in_data = '0;
        for (int p = 0; p < NP; p++) fp_cnt[p] = 0;
        forever begin
            @(negedge clk);
            fire_s    = in_valid & in_ready;
            fp_fire_s = fp_in_valid & fp_in_ready;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (fire_s[p] && src_q[p].size() > 0) src_q[p].delete(0);
                hold = in_valid[p] && !fire_s[p];
                if (src_q[p].size() == 0) begin
                    in_valid[p] = 1'b0;
                    in_last[p]  = 1'b0;
                end else begin
                    in_data[p*DW +: DW] = src_q[p][0].data;
                    in_last[p]  = src_q[p][0].last;
                    in_valid[p] = hold || src_q[p][0].first || !gap_en ||
                                  ($urandom_range(0, 3) != 0);
                end
                if (fp_fire_s[p]) fp_cnt[p] = (fp_cnt[p] == 2) ? 0 : fp_cnt[p] + 1;
                fp_in_last[p] = (fp_cnt[p] == 2);
            end
            case (ready_mode)
                1:       out_ready = ($urandom_range(0, 1) == 1);
                2:       out_ready = !out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        exp_t          e;
        logic          prev_stall;
        logic [DW-1:0] pd;
        logic          pl;
        logic [PW-1:0] pp;
        prev_stall = 1'b0; pd = '0; pl = 1'b0; pp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl ||
                        out_port !== pp) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h l=%b p=%0d, required v=1 d=%h l=%b p=%0d",
                                 out_valid, out_data, out_last, out_port, pd, pl, pp);
                    end
                end
                if (out_valid && out_ready) begin
                    if (timing_en) fire_off.push_back(cyc - t0);
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got d=%h p=%0d, required no beat",
                                 out_data, out_port);
                    end else begin
                        e = sb_q.pop_front();
                        if (out_data !== e.data || out_last !== e.last || out_port !== e.port ||
                            trunc_pulse !== e.trunc) begin
                            errors++;
                            $display("FAIL beat: got d=%h l=%b p=%0d t=%b, required d=%h l=%b p=%0d t=%b",
                                     out_data, out_last, out_port, trunc_pulse,
                                     e.data, e.last, e.port, e.trunc);
                        end
                    end
                end else begin
                    checks++;
                    if (trunc_pulse !== 1'b0) begin
                        errors++;
                        $display("FAIL trunc_idle: got %b, required 0", trunc_pulse);
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data; pl = out_last; pp = out_port;
                if (fp_out_valid) begin
                    fp_fires++;
                    checks++;
                    if (fp_out_port !== 2'd1 || fp_in_ready[2] !== 1'b0) begin
                        errors++;
                        $display("FAIL fixed_prio: got port=%0d ready2=%b, required port=1 ready2=0",
                                 fp_out_port, fp_in_ready[2]);
                    end
                end
            end
        end
    end

    function automatic bit any_pending();
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_pkt(input int p, input int len, input logic [DW-1:0] start);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = DW'(int'(start) + i);
            b.last  = (i == len - 1);
            b.first = (i == 0);
            src_q[p].push_back(b);
        end
    endtask

    // Reference: all masked ports offer at once, so grants follow pure round-robin order.
    task automatic run_round(input logic [NP-1:0] mask);
        logic [NP-1:0] rem;
        exp_t          e;
        int            fwd, w;
        @(posedge clk);
        #2;
        t0 = cyc;
        fire_off.delete();
        rem = mask;
        for (int n = 0; n < NP; n++) begin
            int pick;
            pick = -1;
            for (int k = 0; k < NP; k++)
                if (pick < 0 && rem[(model_rr + k) % NP]) pick = (model_rr + k) % NP;
            if (pick >= 0) begin
                fwd = (r_len[pick] > MAXB) ? MAXB : r_len[pick];
                for (int i = 0; i < fwd; i++) begin
                    e.data  = DW'(int'(r_start[pick]) + i);
                    e.last  = (i == fwd - 1);
                    e.port  = PW'(pick);
                    e.trunc = (r_len[pick] > MAXB) && (i == fwd - 1);
                    sb_q.push_back(e);
                end
                model_pkts[pick]++;
                if (r_len[pick] > MAXB) model_truncs[pick]++;
                rem[pick] = 1'b0;
                model_rr  = (pick + 1) % NP;
            end
        end
        for (int p = 0; p < NP; p++) if (mask[p]) load_pkt(p, r_len[p], r_start[p]);
        w = 0;
        while ((sb_q.size() != 0 || any_pending()) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        if (w >= 2000) begin
            checks++;
            errors++;
            $display("FAIL round_timeout: got %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
            for (int p = 0; p < NP; p++) src_q[p].delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic check_offsets(input int n, input int gap_after);
        int exp_off;
        checks++;
        if (fire_off.size() != n) begin
            errors++;
            $display("FAIL fire_count: got %0d, required %0d", fire_off.size(), n);
        end
        for (int i = 0; i < n && i < fire_off.size(); i++) begin
            exp_off = 2 + i + ((gap_after > 0 && i >= gap_after) ? 1 : 0);
            checks++;
            if (fire_off[i] != exp_off) begin
                errors++;
                $display("FAIL fire_timing[%0d]: got offset %0d, required %0d",
                         i, fire_off[i], exp_off);
            end
        end
    endtask

`ifdef PORT_STATS_EN
    task automatic check_stats();
        for (int p = 0; p < NP; p++) begin
            stat_sel = PW'(p);
            #1;
            checks++;
            if (stat_pkts !== 32'(model_pkts[p]) || stat_truncs !== 32'(model_truncs[p])) begin
                errors++;
                $display("FAIL stats[%0d]: got pkts=%0d truncs=%0d, required pkts=%0d truncs=%0d",
                         p, stat_pkts, stat_truncs, model_pkts[p], model_truncs[p]);
            end
        end
    endtask
`endif

    initial begin : main
        rst = 1'b1;
`ifdef PORT_STATS_EN
        stat_sel = '0;
`endif
        for (int p = 0; p < NP; p++) begin
            model_pkts[p] = 0; model_truncs[p] = 0; r_len[p] = 1; r_start[p] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({out_valid, out_last, busy, trunc_pulse, in_ready, out_port} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b, required all zero",
                     {out_valid, out_last, busy, trunc_pulse, in_ready, out_port});
        end
        rst = 1'b0;

        // Single port 2, 5 beats 0x10..0x14: one bubble then back-to-back beats.
        timing_en = 1'b1;
        r_len[2] = 5; r_start[2] = 8'h10;
        run_round(4'b0100);
        check_offsets(5, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_pkt: got busy=%b, required 0", busy);
        end

        // Ports 0 and 3 with 3-beat packets: alternate with exactly one bubble.
        r_len[0] = 3; r_start[0] = 8'h40; r_len[3] = 3; r_start[3] = 8'hC0;
        run_round(4'b1001);
        check_offsets(6, 3);
        r_start[0] = 8'h50; r_start[3] = 8'hD0;
        run_round(4'b1001);
        timing_en = 1'b0;

        // Truncation: 9-beat packet forwards MAXB beats; exact-MAXB packet is intact.
        r_len[0] = 9; r_start[0] = 8'h80;
        run_round(4'b0001);
        r_len[0] = MAXB; r_start[0] = 8'h90;
        run_round(4'b0001);
        r_len[0] = MAXB + 1; r_start[0] = 8'hA0;
        run_round(4'b0001);
        r_len[1] = 1; r_start[1] = 8'h77;
        run_round(4'b0010);

        // Alternating out_ready during a 6-beat packet.
        ready_mode = 2;
        r_len[1] = 6; r_start[1] = 8'h20;
        run_round(4'b0010);

        gap_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            ready_mode = $urandom_range(0, 2);
            for (int p = 0; p < NP; p++) begin
                r_len[p]   = $urandom_range(1, MAXB + 3);
                r_start[p] = DW'($urandom);
            end
            run_round(NP'($urandom_range(1, 15)));
        end
`ifdef PORT_STATS_EN
        check_stats();
`endif

        // Reset during beat 3 of a port-1 packet.
        gap_en = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #2;
        t0 = cyc;
        for (int i = 0; i < 2; i++) sb_q.push_back('{data: DW'(8'h60 + i), last: 1'b0,
                                                    port: PW'(1), trunc: 1'b0});
        load_pkt(1, 6, 8'h60);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, busy, trunc_pulse, in_ready, out_port} !== '0) begin
            errors++;
            $display("FAIL reset_midpkt: got %b, required all zero",
                     {out_valid, out_last, busy, trunc_pulse, in_ready, out_port});
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_beats: got %0d outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            model_pkts[p] = 0;
            model_truncs[p] = 0;
        end
        model_rr = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
`ifdef PORT_STATS_EN
        check_stats();
`endif
        r_len[1] = 3; r_start[1] = 8'h33;
        run_round(4'b0010);
`ifdef PORT_STATS_EN
        check_stats();
`endif

        checks++;
        if (fp_fires < 20) begin
            errors++;
            $display("FAIL fixed_prio_progress: got %0d beats, required at least 20", fp_fires);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataplane_port_arbiter.md
Name: dataplane_port_arbiter

Overview:
- Packet-atomic N-to-1 ingress arbiter that merges NUM_PORTS independent MAC RX byte-streams into the single rx_valid/rx_data/rx_last/rx_ready lane of the dataplane.
- Grants one port per packet, using round-robin or fixed priority, and tags each forwarded beat with its source port.
- Enforces a maximum packet length: an oversized packet is truncated and its remainder is discarded at the source.
- Generalises the single-port ingress of the dataplane to multi-port, configurable-width operation.

Parameters:
- NUM_PORTS, 4, number of ingress channels (>=2).
- DATA_W, 8, beat width in bits.
- MAX_PKT_BEATS, 1518, maximum beats forwarded per packet (>=2).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- PORT_W, $clog2(NUM_PORTS), port-index width (derived).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_PORTS  per-port beat valid.
- in_data  input  NUM_PORTS*DATA_W  per-port data; port p occupies bits [p*DATA_W +: DATA_W].
- in_last  input  NUM_PORTS  per-port end-of-packet.
- in_ready  output  NUM_PORTS  per-port ready.
- out_valid  output  1  merged beat valid (feeds dataplane rx_valid).
- out_data  output  DATA_W  merged data.
- out_last  output  1  merged end-of-packet; also forced high on truncation.
- out_port  output  PORT_W  source port of the current beat.
- out_ready  input  1  downstream ready.
- busy  output  1  high in FWD or DISCARD.
- trunc_pulse  output  1  one-cycle pulse when a packet is truncated.

Behaviour:
- Reset values: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. All in_ready, out_valid, out_last, busy and trunc_pulse are 0; out_port=0; out_data is don't-care.
- Fire definitions:
  - Input fire: in_valid[p] & in_ready[p].
  - Output fire: out_valid & out_ready.
- IDLE:
  - All in_ready=0 and out_valid=0.
  - If any in_valid is set, select a winner:
    - ARB_MODE=0: first asserted port searching from rr_ptr upward, wrapping modulo NUM_PORTS.
    - ARB_MODE=1: lowest asserted index.
  - Register grant=winner, clear beat_cnt, go to FWD the next cycle. Arbitration therefore costs one bubble cycle per packet.
- FWD:
  - Outputs are a combinational pass-through of the granted port: out_valid=in_valid[grant], out_data=in_data[grant], out_port=grant, in_ready[grant]=out_ready. All other in_ready are 0.
  - On every output fire, beat_cnt increments (width $clog2(MAX_PKT_BEATS+1)).
  - Output fire with in_last[grant]=1: go to IDLE and set rr_ptr=(grant+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
  - Truncation: when beat_cnt==MAX_PKT_BEATS-1, in_last[grant]=0 and a beat is present, out_last is forced 1. On that fire, trunc_pulse=1 for one cycle and the next state is DISCARD.
  - A packet of exactly MAX_PKT_BEATS beats with its real last on the final beat is not truncated.
- DISCARD:
  - in_ready[grant]=1 and out_valid=0; beats are consumed and dropped.
  - On input fire with in_last[grant]=1, go to IDLE and advance rr_ptr as above.
- rr_ptr is updated only at packet completion; ARB_MODE=1 ignores it.
- A single-beat packet (in_last on the first beat) completes in FWD in one fire.
- in_valid dropping mid-packet: the block holds the grant with no timeout; other ports starve until the granted packet ends.
- out_ready low: the granted port stalls; no beat is lost or duplicated, and out_data/out_last stay stable while out_valid & !out_ready.
- Reset asserted mid-packet: the block returns immediately to IDLE with no flush. The partial packet downstream is the dataplane's responsibility.
- busy = (state != IDLE).

Optional Feature:
- Macro PORT_STATS_EN.
- When defined, the block adds:
  - input stat_sel [PORT_W-1:0];
  - output stat_pkts [31:0], the count of packets completed on port stat_sel (FWD real last, or DISCARD last);
  - output stat_truncs [31:0], the count of truncations on port stat_sel.
- Both counters are per-port, saturate at 32'hFFFFFFFF and are cleared by rst. The read is combinational on stat_sel.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single port 2 sends 5-beat packet 0x10..0x14 while others are idle -> one idle cycle, then 5 out beats with out_port=2, out_last on 0x14 only; back to IDLE.
- ARB_MODE=0, ports 0 and 3 continuously offer 3-beat packets -> packets alternate 0,3,0,3 with exactly one bubble between them.
- ARB_MODE=1, ports 1 and 2 continuously offering -> port 1 wins every arbitration and port 2 starves.
- MAX_PKT_BEATS=4, port 0 sends a 7-beat packet -> 4 out beats with out_last forced on beat 4, trunc_pulse for 1 cycle, beats 5-7 consumed with out_valid=0; a 4-beat packet on the same port is not truncated.
- Toggle out_ready 1010... during a 6-beat packet -> the exact 6-beat sequence is seen with no loss or duplication and data held stable while stalled.
- Assert rst during beat 3 of a packet -> all outputs go to 0 the same cycle; after release, a new packet on port 1 is granted normally. With PORT_STATS_EN, stat_pkts for the interrupted port reads 0.
